dlfloat_mac_sequencer: RTL and testbench

//  Controller for the DLFloat16 MAC datapath (1s/6e bias 31/9m; 16'hFFFF = NaN/Inf).

---
 rtl/dlfloat_mac_sequencer.sv | 161 ++++++++++++++++
 tb/tb_dlfloat_mac_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dlfloat_mac_sequencer.sv
// Job sequencer for the DLFloat16 MAC: streams a/b operand pairs into the MAC,
// waits out its pipeline, then returns the 16-bit accumulator as two bytes.
module dlfloat_mac_sequencer #(
  parameter int MAC_LAT = 2,
  parameter int LEN_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic [15:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [15:0]      mac_a,
  output logic [15:0]      mac_b,
  output logic             mac_en,
  output logic             acc_clr,
  input  logic [15:0]      acc_in,
  output logic [7:0]       out_byte,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             nan_seen,
  output logic [2:0]       dbg_state
);

  // Both ports are valid/ready: a word moves only in a cycle where valid and
  // ready are both high; valid never drops and data never changes while waiting.
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD_A, S_LOAD_B, S_ISSUE, S_DRAIN, S_OUT_HI, S_OUT_LO
  } state_t;

  localparam int LAT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MAC_LAT - 1);

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W:0]   pair_cnt;
  logic [LAT_W-1:0] lat_cnt;
  logic [15:0]      result;
  logic             aborting;
  logic [15:0]      drain_val;
  logic [LEN_W:0]   pair_next;

  // An empty job never issues mac_en, so the accumulator is not consulted.
  assign drain_val = (len_q == '0) ? 16'h0000 : acc_in;
  assign pair_next = pair_cnt + 1'b1;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      len_q     <= '0;
      pair_cnt  <= '0;
      lat_cnt   <= '0;
      result    <= '0;
      aborting  <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
      mac_en    <= 1'b0;
      acc_clr   <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_byte  <= '0;
      busy      <= 1'b0;
      nan_seen  <= 1'b0;
    end else begin
      mac_en  <= 1'b0;
      acc_clr <= 1'b0;
      if (abort && state != S_IDLE) begin
        state     <= S_CLEAR;
        aborting  <= 1'b1;
        acc_clr   <= 1'b1;
        in_ready  <= 1'b0;
        out_valid <= 1'b0;
        out_byte  <= '0;
        busy      <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              len_q    <= len;
              nan_seen <= 1'b0;
              pair_cnt <= '0;
              aborting <= 1'b0;
              acc_clr  <= 1'b1;
              busy     <= 1'b1;
              state    <= S_CLEAR;
            end
          end
          S_CLEAR: begin
            if (aborting) begin
              aborting <= 1'b0;
              busy     <= 1'b0;
              state    <= S_IDLE;
            end else if (len_q == '0) begin
              lat_cnt <= '0;
              state   <= S_DRAIN;
            end else begin
              in_ready <= 1'b1;
              state    <= S_LOAD_A;
            end
          end
          S_LOAD_A: begin
            if (in_valid) begin
              mac_a <= in_data;
              if (in_data == 16'hFFFF) nan_seen <= 1'b1;
              state <= S_LOAD_B;
            end
          end
          S_LOAD_B: begin
            if (in_valid) begin
              mac_b    <= in_data;
              if (in_data == 16'hFFFF) nan_seen <= 1'b1;
              in_ready <= 1'b0;
              mac_en   <= 1'b1;
              state    <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            pair_cnt <= pair_next;
            if (pair_next == {1'b0, len_q}) begin
              lat_cnt <= '0;
              state   <= S_DRAIN;
            end else begin
              in_ready <= 1'b1;
              state    <= S_LOAD_A;
            end
          end
          S_DRAIN: begin
            if (lat_cnt == LAT_LAST) begin
              result    <= drain_val;
              out_byte  <= drain_val[15:8];
              out_valid <= 1'b1;
              state     <= S_OUT_HI;
            end else begin
              lat_cnt <= lat_cnt + 1'b1;
            end
          end
          S_OUT_HI: begin
            if (out_ready) begin
              out_byte <= result[7:0];
              state    <= S_OUT_LO;
            end
          end
          S_OUT_LO: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              out_byte  <= '0;
              busy      <= 1'b0;
              state     <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dlfloat_mac_sequencer.sv
// Bench for dlfloat_mac_sequencer: behavioural DLFloat MAC, directed scenarios,
// randomized jobs checked against a real-arithmetic dot-product model.
module tb_dlfloat_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        abort = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] mac_a, mac_b;
  logic        mac_en, acc_clr;
  logic [15:0] acc_in;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy, nan_seen;
  logic [2:0]  dbg_state;

  dlfloat_mac_sequencer #(.MAC_LAT(2), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mac_a(mac_a), .mac_b(mac_b), .mac_en(mac_en), .acc_clr(acc_clr),
    .acc_in(acc_in), .out_byte(out_byte), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .nan_seen(nan_seen), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // DLFloat16 <-> real, 1s/6e bias 31/9m, all-zero magnitude is zero
  function automatic real dl2r(input logic [15:0] x);
    real r;
    int  e;
    if (x[14:0] == 15'd0) return 0.0;
    r = 1.0 + real'(x[8:0]) / 512.0;
    e = int'(x[14:9]) - 31;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return x[15] ? -r : r;
  endfunction

  function automatic logic [15:0] r2dl(input real v);
    real a;
    int  e;
    logic [5:0] ee;
    logic [8:0] mm;
    if (v == 0.0) return 16'h0000;
    a = (v < 0.0) ? -v : v;
    e = 31;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    ee = 6'(e);
    mm = 9'($rtoi((a - 1.0) * 512.0));
    return {(v < 0.0), ee, mm};
  endfunction

  // Behavioural MAC: product registered on mac_en, accumulated the cycle after
  real  acc_r, p1;
  logic p1v, p1n, nan_r;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= 0.0; p1 <= 0.0; p1v <= 1'b0; p1n <= 1'b0; nan_r <= 1'b0; acc_in <= '0;
    end else if (acc_clr) begin
      acc_r <= 0.0; p1v <= 1'b0; p1n <= 1'b0; nan_r <= 1'b0; acc_in <= '0;
    end else begin
      if (p1v) begin
        acc_r  <= acc_r + p1;
        nan_r  <= nan_r | p1n;
        acc_in <= (nan_r | p1n) ? 16'hFFFF : r2dl(acc_r + p1);
      end
      p1v <= mac_en;
      p1  <= dl2r(mac_a) * dl2r(mac_b);
      p1n <= (mac_a == 16'hFFFF) || (mac_b == 16'hFFFF);
    end
  end

  logic [15:0] ops[$];
  int mac_en_cnt, clr_cnt, rdy_cnt, ov_cnt, pair_k;

  always @(negedge clk) begin
    if (mac_en) begin
      check($sformatf("mac_ab_pair%0d", pair_k), {mac_a, mac_b},
            {ops[2*pair_k], ops[2*pair_k+1]});
      pair_k++;
      mac_en_cnt++;
    end
    if (acc_clr)   clr_cnt++;
    if (in_ready)  rdy_cnt++;
    if (out_valid) ov_cnt++;
  end

  task automatic zero_counts();
    mac_en_cnt = 0; clr_cnt = 0; rdy_cnt = 0; ov_cnt = 0; pair_k = 0;
  endtask

  task automatic start_job(input int l);
    zero_counts();
    @(negedge clk);
    start = 1'b1;
    len   = 8'(l);
    @(negedge clk);
    start = 1'b0;
    len   = 8'($urandom_range(0, 255));
  endtask

  task automatic feed(input int nwords, input bit rnd);
    int idx = 0;
    int guard = 0;
    while (idx < nwords && guard < 4000) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = in_valid ? ops[idx] : 16'($urandom);
      if (in_valid && in_ready) idx++;
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    if (guard >= 4000) check("feed_timeout", 64'(idx), 64'(nwords));
  endtask

  task automatic consume(output logic [15:0] got, input int hold, input bit rnd,
                         input logic [7:0] exp_hi);
    int n = 0;
    int guard = 0;
    bit stable;
    got = '0;
    while (n < 2 && guard < 5000) begin
      if (out_valid && n == 0 && hold > 0) begin
        out_ready = 1'b0;
        stable = 1'b1;
        repeat (hold) begin
          @(negedge clk);
          if (out_byte !== exp_hi || out_valid !== 1'b1) stable = 1'b0;
        end
        check("hold_byte_stable", 64'(stable), 64'd1);
        hold = 0;
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        if (n == 0) got[15:8] = out_byte; else got[7:0] = out_byte;
        n++;
      end
      @(negedge clk);
      guard++;
    end
    out_ready = 1'b0;
    if (guard >= 5000) check("out_timeout", 64'(n), 64'd2);
  endtask

  // Reference: plain dot product of the operand list, NaN if any operand is FFFF
  function automatic logic [15:0] ref_result(input int l);
    real s = 0.0;
    bit  nan = 1'b0;
    for (int i = 0; i < l; i++) begin
      if (ops[2*i] == 16'hFFFF || ops[2*i+1] == 16'hFFFF) nan = 1'b1;
      s = s + dl2r(ops[2*i]) * dl2r(ops[2*i+1]);
    end
    return nan ? 16'hFFFF : r2dl(s);
  endfunction

  function automatic bit ref_nan(input int l);
    for (int i = 0; i < 2*l; i++) if (ops[i] == 16'hFFFF) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_job(input string tag, input int l, input bit rnd_in,
                         input bit rnd_out, input int hold, input bit poke);
    logic [15:0] exp, got;
    exp = ref_result(l);
    start_job(l);
    check({tag, "_nan_cleared"}, 64'(nan_seen), 64'd0);
    fork
      feed(2*l, rnd_in);
      consume(got, hold, rnd_out, exp[15:8]);
      begin
        if (poke) begin
          repeat (4) @(negedge clk);
          start = 1'b1; len = 8'd0;
          @(negedge clk);
          start = 1'b0;
        end
      end
    join
    check({tag, "_result"}, 64'(got), 64'(exp));
    check({tag, "_mac_en_cnt"}, 64'(mac_en_cnt), 64'(l));
    check({tag, "_acc_clr_cnt"}, 64'(clr_cnt), 64'd1);
    check({tag, "_busy_done"}, 64'(busy), 64'd0);
    check({tag, "_nan_seen"}, 64'(nan_seen), 64'(ref_nan(l)));
    if (l == 0) check({tag, "_no_in_ready"}, 64'(rdy_cnt), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  localparam logic [15:0] TBL [7] = '{16'h3E00, 16'h4000, 16'h3C00, 16'hBE00,
                                      16'h3F00, 16'h0000, 16'hFFFF};

  initial begin
    int l;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {mac_a, mac_b, out_byte, mac_en, acc_clr, in_ready, out_valid, busy, nan_seen},
          64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // abort while idle does nothing
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    check("abort_idle_busy", {63'd0, busy}, 64'd0);
    check("abort_idle_no_clr", {63'd0, acc_clr}, 64'd0);

    ops = '{16'h3E00, 16'h4000};
    run_job("s1", 1, 0, 0, 0, 0);
    ops = '{16'h3E00, 16'h4000, 16'h3E00, 16'h3E00};
    run_job("s2", 2, 0, 0, 0, 0);
    ops = '{};
    run_job("s3", 0, 0, 0, 0, 0);
    ops = '{16'h3E00, 16'h4000, 16'h3E00, 16'h3E00};
    run_job("s4", 2, 1, 0, 10, 1);
    ops = '{16'h3E00, 16'hFFFF, 16'h3E00, 16'h3E00};
    run_job("s5", 2, 0, 0, 0, 0);

    // abort during LOAD_B of pair 2
    ops = '{16'h3E00, 16'h4000, 16'h3E00, 16'h3E00};
    start_job(2);
    feed(3, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_clr_cnt", 64'(clr_cnt), 64'd2);
    check("abort_mac_en_cnt", 64'(mac_en_cnt), 64'd1);
    repeat (20) @(negedge clk);
    check("abort_no_out_valid", 64'(ov_cnt), 64'd0);

    // async reset while ISSUE is driving mac_en
    ops = '{16'h3E00, 16'h4000};
    start_job(1);
    feed(2, 0);
    check("pre_reset_issue", 64'(mac_en), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {mac_a, mac_b, out_byte, mac_en, acc_clr, in_ready, out_valid, busy, nan_seen},
          64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_job("s6_after_reset", 1, 0, 0, 0, 0);

    for (int j = 0; j < 6; j++) begin
      l = $urandom_range(0, 6);
      ops = '{};
      for (int i = 0; i < 2*l; i++) ops.push_back(TBL[$urandom_range(0, 6)]);
      run_job($sformatf("rnd%0d", j), l, 1, 1, $urandom_range(0, 3), 0);
    end

    // longest job: counter must reach 255 without wrapping
    ops = '{};
    for (int i = 0; i < 510; i++) ops.push_back(16'h3E00);
    run_job("len255", 255, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
